// File: rtl/riscv_muldiv_arbiter_pkg.sv
// Shared types and constants for the MUL/DIV issue arbiter.
// Op encoding, fixed unit latencies, FSM state encoding and small op helpers.
package riscv_muldiv_arbiter_pkg;

   // RISC-V M-extension op encoding; the bit index of the one-hot issue vector equals the code
   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   // Cycles from an accepted unit issue to the cycle in which md_wb_* is valid
   localparam int unsigned MD_MUL_LATENCY = 2;
   localparam int unsigned MD_DIV_LATENCY = 34;

   // Wide enough for the divider latency
   localparam int unsigned CNT_W = 6;

   // IDLE: arbitrate; ISSUE: present op to unit; WAIT: count to result; DRAIN: flushed op finishing
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } md_state_e;

   // DIV/DIVU/REM/REMU all have bit 2 set
   function automatic logic is_div_op(input muldiv_op_e op);
      logic [2:0] w_bits;
      w_bits = op;
      return w_bits[2];
   endfunction

   // One-hot instruction vector for the unit
   function automatic logic [7:0] op_onehot(input muldiv_op_e op);
      logic [2:0] w_bits;
      w_bits = op;
      return 8'b0000_0001 << w_bits;
   endfunction

endpackage

// File: rtl/riscv_muldiv_arbiter_if.sv
// Bus bundle between the two issue pipes, the shared MUL/DIV unit and the arbiter.
// Handshake rule: a request transfers in the cycle where reqN_valid_i and reqN_ready_o
// are both high; valid is held by the requester until then; ready is only ever high in
// IDLE without flush and for at most one requester. The unit accepts an issue in a cycle
// with md_valid_o high and md_stall_i low. resp_valid_o is a one-cycle pulse, never
// back-pressured.
// The master modport is the arbiter's view (it masters the unit); slave is the
// surrounding core / unit view.
interface riscv_muldiv_arbiter_if
   import riscv_muldiv_arbiter_pkg::*;
;
   logic        req0_valid_i;
   logic        req0_ready_o;
   muldiv_op_e  req0_op_i;
   logic [4:0]  req0_rd_i;
   logic [31:0] req0_ra_i;
   logic [31:0] req0_rb_i;

   logic        req1_valid_i;
   logic        req1_ready_o;
   muldiv_op_e  req1_op_i;
   logic [4:0]  req1_rd_i;
   logic [31:0] req1_ra_i;
   logic [31:0] req1_rb_i;

   logic        md_valid_o;
   logic [7:0]  md_instr_o;
   logic [4:0]  md_rd_o;
   logic [31:0] md_ra_o;
   logic [31:0] md_rb_o;
   logic        md_stall_i;
   logic [4:0]  md_wb_idx_i;
   logic [31:0] md_wb_value_i;

   logic        resp_valid_o;
   logic        resp_id_o;
   logic [4:0]  resp_rd_o;
   logic [31:0] resp_value_o;

   logic        busy_o;
   logic [4:0]  busy_rd_o;
   logic        error_o;

   modport master (
      input  req0_valid_i, req0_op_i, req0_rd_i, req0_ra_i, req0_rb_i,
      input  req1_valid_i, req1_op_i, req1_rd_i, req1_ra_i, req1_rb_i,
      output req0_ready_o, req1_ready_o,
      output md_valid_o, md_instr_o, md_rd_o, md_ra_o, md_rb_o,
      input  md_stall_i, md_wb_idx_i, md_wb_value_i,
      output resp_valid_o, resp_id_o, resp_rd_o, resp_value_o,
      output busy_o, busy_rd_o, error_o
   );

   modport slave (
      output req0_valid_i, req0_op_i, req0_rd_i, req0_ra_i, req0_rb_i,
      output req1_valid_i, req1_op_i, req1_rd_i, req1_ra_i, req1_rb_i,
      input  req0_ready_o, req1_ready_o,
      input  md_valid_o, md_instr_o, md_rd_o, md_ra_o, md_rb_o,
      output md_stall_i, md_wb_idx_i, md_wb_value_i,
      input  resp_valid_o, resp_id_o, resp_rd_o, resp_value_o,
      input  busy_o, busy_rd_o, error_o
   );

endinterface

// File: rtl/riscv_muldiv_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// Grants are combinational; the pointer moves to the losing side on every grant,
// so a lone requester also hands priority to the other side.
module riscv_rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] i_req,
   input  logic       i_en,
   output logic [1:0] o_gnt
);

   logic       r_ptr;   // 0: req0 has priority, 1: req1 has priority
   logic [1:0] w_gnt;

   // Pick one winner: a sole requester wins, a tie goes to the pointer side
   always_comb begin
      w_gnt = 2'b00;
      if (i_en) begin
         if (i_req == 2'b11) begin
            w_gnt = r_ptr ? 2'b10 : 2'b01;
         end else begin
            w_gnt = i_req;
         end
      end
   end

   // Hand priority to the side that did not win
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr <= 1'b0;
      end else if (|w_gnt) begin
         r_ptr <= w_gnt[0];
      end
   end

   assign o_gnt = w_gnt;

endmodule

// File: rtl/riscv_muldiv_arbiter.sv
// Shares one iterative MUL/DIV unit between two issue pipes.
// Round-robin grant in IDLE, one issue cycle (held while the unit stalls), then a fixed
// latency count to the writeback cycle, whose value is registered into a one-cycle
// tagged response. A flush while waiting cannot abort the divider, so the op drains
// silently before the next grant. busy/busy_rd feed the issue scoreboard.
// Latencies are assumed to be at least 1.
module riscv_muldiv_arbiter
   import riscv_muldiv_arbiter_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = MD_MUL_LATENCY,
   parameter int unsigned DIV_LATENCY = MD_DIV_LATENCY
)(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   riscv_muldiv_arbiter_if.master io_bus,
   output md_state_e              o_dbg_state
);

   md_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_id;
   muldiv_op_e       r_op;
   logic [4:0]       r_rd;
   logic [31:0]      r_ra;
   logic [31:0]      r_rb;
   logic             r_resp_valid;
   logic             r_resp_id;
   logic [4:0]       r_resp_rd;
   logic [31:0]      r_resp_value;
   logic             r_error;

   logic [1:0]       w_req;
   logic [1:0]       w_gnt;
   logic             w_arb_en;
   muldiv_op_e       w_sel_op;
   logic [4:0]       w_sel_rd;
   logic [31:0]      w_sel_ra;
   logic [31:0]      w_sel_rb;
   logic [CNT_W-1:0] w_cnt_load;
   logic             w_wb_mismatch;

   assign w_req    = {io_bus.req1_valid_i, io_bus.req0_valid_i};
   assign w_arb_en = (r_state == ST_IDLE) && !flush_i;

   riscv_rr_arb2 u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .i_req (w_req),
      .i_en  (w_arb_en),
      .o_gnt (w_gnt)
   );

   assign io_bus.req0_ready_o = w_gnt[0];
   assign io_bus.req1_ready_o = w_gnt[1];

   // Select the winning requester's fields for latching
   always_comb begin
      w_sel_op = io_bus.req0_op_i;
      w_sel_rd = io_bus.req0_rd_i;
      w_sel_ra = io_bus.req0_ra_i;
      w_sel_rb = io_bus.req0_rb_i;
      if (w_gnt[1]) begin
         w_sel_op = io_bus.req1_op_i;
         w_sel_rd = io_bus.req1_rd_i;
         w_sel_ra = io_bus.req1_ra_i;
         w_sel_rb = io_bus.req1_rb_i;
      end
   end

   assign w_cnt_load    = is_div_op(r_op) ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY);
   // x0 writes are architecturally discarded, so the unit's index is not checked for them
   assign w_wb_mismatch = (r_rd != 5'd0) && (io_bus.md_wb_idx_i != r_rd);

   // Issue/complete FSM with latched operands, latency counter and response registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_id         <= 1'b0;
         r_op         <= OP_MUL;
         r_rd         <= 5'd0;
         r_ra         <= 32'd0;
         r_rb         <= 32'd0;
         r_resp_valid <= 1'b0;
         r_resp_id    <= 1'b0;
         r_resp_rd    <= 5'd0;
         r_resp_value <= 32'd0;
         r_error      <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|w_gnt) begin
                  r_id    <= w_gnt[1];
                  r_op    <= w_sel_op;
                  r_rd    <= w_sel_rd;
                  r_ra    <= w_sel_ra;
                  r_rb    <= w_sel_rb;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (flush_i) begin
                  r_state <= ST_IDLE;
               end else if (!io_bus.md_stall_i) begin
                  r_cnt   <= w_cnt_load;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt == CNT_W'(1)) begin
                  // Writeback cycle; a flush landing here drops the result
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
                  if (!flush_i) begin
                     r_resp_valid <= 1'b1;
                     r_resp_id    <= r_id;
                     r_resp_rd    <= r_rd;
                     r_resp_value <= io_bus.md_wb_value_i;
                     if (w_wb_mismatch) begin
                        r_error <= 1'b1;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (flush_i) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Unit issue is masked by a same-cycle flush so a killed op never reaches the unit
   assign io_bus.md_valid_o    = (r_state == ST_ISSUE) && !flush_i;
   assign io_bus.md_instr_o    = (r_state == ST_ISSUE) ? op_onehot(r_op) : 8'd0;
   assign io_bus.md_rd_o       = r_rd;
   assign io_bus.md_ra_o       = r_ra;
   assign io_bus.md_rb_o       = r_rb;

   assign io_bus.resp_valid_o  = r_resp_valid;
   assign io_bus.resp_id_o     = r_resp_id;
   assign io_bus.resp_rd_o     = r_resp_rd;
   assign io_bus.resp_value_o  = r_resp_value;

   assign io_bus.busy_o        = (r_state != ST_IDLE);
   assign io_bus.busy_rd_o     = (r_state != ST_IDLE) ? r_rd : 5'd0;
   assign io_bus.error_o       = r_error;

   assign o_dbg_state          = r_state;

endmodule
